// File: rtl/add32_arbiter.sv
// add32_arbiter
//   Lets two requesters share one 32-bit add/sub datapath (add32). The
//   request that wins arbitration has its operands registered onto the adder
//   port. The sum and flags, plus a zero flag derived from the sum, are then
//   captured and returned to the winner over a valid/ready handshake.
//   At most one operation is in flight: IDLE -> EXEC -> RESP -> IDLE.
//
// Build option:
//   ADD32_ARB_FIXED_PRIO_EN  defined   : requester 0 always wins contention
//                            undefined : round-robin, starting at FIRST_GRANT
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/ready/a/b/m{0,1}      operation request per requester (m: 1=sub)
//   add_a, add_b, add_m             registered operands to the adder
//   add_s, add_cf, add_of           combinational adder result
//   rsp_valid{0,1}, rsp_ready{0,1}  result handshake per requester
//   rsp_s, rsp_cf, rsp_of, rsp_zero shared result bus
//   busy                            an operation is in flight

// Per-requester handshake gating. Instantiated once for each requester.
module add32_arb_port (
  input  logic idle_i,      // controller can accept a request
  input  logic req_valid_i, // this requester has an operation
  input  logic pick_i,      // arbitration selects this requester
  input  logic resp_i,      // controller is presenting a result
  input  logic owner_i,     // in-flight operation belongs to this requester
  output logic req_ready_o,
  output logic rsp_valid_o
);
  assign req_ready_o = idle_i & req_valid_i & pick_i;
  assign rsp_valid_o = resp_i & owner_i;
endmodule

module add32_arbiter #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned FIRST_GRANT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic             req_m0,
  // requester 1
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic             req_m1,
  // adder port
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_m,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cf,
  input  logic             add_of,
  // response
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cf,
  output logic             rsp_of,
  output logic             rsp_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // requester inputs gathered into packed arrays, index = requester id
  logic [1:0]            req_valid;
  logic [1:0][WIDTH-1:0] req_a;
  logic [1:0][WIDTH-1:0] req_b;
  logic [1:0]            req_m;
  logic [1:0]            req_ready;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;

  assign req_valid = {req_valid1, req_valid0};
  assign req_a     = {req_a1, req_a0};
  assign req_b     = {req_b1, req_b0};
  assign req_m     = {req_m1, req_m0};
  assign rsp_ready = {rsp_ready1, rsp_ready0};

  logic [1:0]       state_q, state_d;
  logic             win_q, win_d;     // owner of the in-flight operation
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_m_q, add_m_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic             rsp_cf_q, rsp_cf_d;
  logic             rsp_of_q, rsp_of_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             winner;
  logic [1:0]       pick;
  logic             idle, resp, hs;

  assign idle = (state_q == IDLE);
  assign resp = (state_q == RESP);

  // Arbitration. The winner is only meaningful when some request is valid;
  // req_ready is gated by req_valid, so the value chosen with no request
  // valid is never used.
`ifdef ADD32_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = ~req_valid[0];
  end
`else
  localparam logic FIRST_GRANT_B = FIRST_GRANT[0];

  // Last winner. Reset to the inverse of FIRST_GRANT so that FIRST_GRANT
  // wins the first contention.
  logic last_q, last_d;

  always_comb begin
    if (&req_valid) winner = ~last_q;
    else            winner = ~req_valid[0];
  end

  always_comb begin
    last_d = last_q;
    if (hs) last_d = winner;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= ~FIRST_GRANT_B;
    else        last_q <= last_d;
  end
`endif

  assign pick = {winner, ~winner};

  add32_arb_port u_port [1:0] (
    .idle_i      (idle),
    .req_valid_i (req_valid),
    .pick_i      (pick),
    .resp_i      (resp),
    .owner_i     ({win_q, ~win_q}),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid)
  );

  assign hs = |req_ready;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    add_m_d    = add_m_q;
    rsp_s_d    = rsp_s_q;
    rsp_cf_d   = rsp_cf_q;
    rsp_of_d   = rsp_of_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          add_a_d = req_a[winner];
          add_b_d = req_b[winner];
          add_m_d = req_m[winner];
          win_d   = winner;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // adder is combinational: its result is settled one cycle after
        // the operands were registered
        rsp_s_d    = add_s;
        rsp_cf_d   = add_cf;
        rsp_of_d   = add_of;
        rsp_zero_d = ~|add_s;
        state_d    = RESP;
      end
      RESP: begin
        // only the owner's ready completes the response
        if (rsp_ready[win_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      add_m_q    <= 1'b0;
      rsp_s_q    <= '0;
      rsp_cf_q   <= 1'b0;
      rsp_of_q   <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      add_m_q    <= add_m_d;
      rsp_s_q    <= rsp_s_d;
      rsp_cf_q   <= rsp_cf_d;
      rsp_of_q   <= rsp_of_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign req_ready0 = req_ready[0];
  assign req_ready1 = req_ready[1];
  assign rsp_valid0 = rsp_valid[0];
  assign rsp_valid1 = rsp_valid[1];
  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_m      = add_m_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_cf     = rsp_cf_q;
  assign rsp_of     = rsp_of_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = ~idle;

endmodule

// File: doc/add32_arbiter.md
Name: add32_arbiter

Overview:
- Two-requester controller that shares one 32-bit add/sub datapath (add32: A, B, m in; S, CF, OF out).
- Arbitrates between requesters and registers the winner's operands onto the adder port.
- Captures S, CF and OF plus a derived zero flag, then returns the result to the winning requester over a valid/ready handshake.
- Sits between the ALU-op issue logic and the single add32 instance.

Parameters:
- WIDTH, 32, operand/result width; must match the adder (32).
- FIRST_GRANT, 0, requester that wins the first contention after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid0  input  1  requester 0 has an operation
- req_ready0  output  1  requester 0 operation accepted this cycle
- req_a0  input  WIDTH  requester 0 operand A
- req_b0  input  WIDTH  requester 0 operand B
- req_m0  input  1  requester 0 mode: 0 add, 1 subtract
- req_valid1, req_ready1, req_a1, req_b1, req_m1: same as above, requester 1
- add_a  output  WIDTH  operand A to adder (registered)
- add_b  output  WIDTH  operand B to adder (registered)
- add_m  output  1  mode to adder (registered)
- add_s  input  WIDTH  adder sum
- add_cf  input  1  adder carry/borrow flag
- add_of  input  1  adder signed overflow
- rsp_valid0  output  1  result valid for requester 0
- rsp_valid1  output  1  result valid for requester 1
- rsp_ready0  input  1  requester 0 accepts result
- rsp_ready1  input  1  requester 1 accepts result
- rsp_s  output  WIDTH  result sum (shared bus)
- rsp_cf  output  1  result CF
- rsp_of  output  1  result OF
- rsp_zero  output  1  result is zero (~|S)
- busy  output  1  state != IDLE

Behaviour:
- Reset: synchronous on rising clk with rst_n=0. State=IDLE. All of add_a, add_b, add_m, rsp_s, rsp_cf, rsp_of, rsp_zero and both rsp_valid = 0. Grant pointer = last winner = ~FIRST_GRANT. Any in-flight op is dropped with no response.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. Minimum 3 cycles per operation; no overlap.
- IDLE:
  - Only state in which req_ready can be high; req_ready is combinational from state and req_valid.
  - Exactly one of req_ready0 or req_ready1 is asserted, and only for a valid requester.
  - On the handshake: register the winner's a, b, m into add_a/add_b/add_m, record winner id, go to EXEC.
  - Nothing valid: stay in IDLE; add_* hold their previous values.
- Arbitration:
  - Single request: it wins.
  - Both valid: round-robin, the winner is the requester that did not win last; the pointer updates on every grant.
- EXEC:
  - Adder is combinational. Register add_s -> rsp_s, add_cf -> rsp_cf, add_of -> rsp_of, ~|add_s -> rsp_zero. Go to RESP.
- RESP:
  - Only rsp_valid of the winner id is high; rsp_* stay stable until handshake.
  - On rsp_ready of the winner: go to IDLE and drop rsp_valid the next cycle. rsp_* data holds its last value.
  - rsp_ready of the non-winner is ignored.
- Latency: request handshake in cycle N -> rsp_valid high in cycle N+2.
- Throughput: next acceptance at earliest one cycle after the response handshake.
- Flag semantics (carried through from the adder): subtract is A+~B+1. rsp_cf = carry XOR m, so for subtract it is a borrow (1 when A<B unsigned). rsp_of = signed overflow.
- Backpressure: rsp_ready low holds RESP indefinitely. Both req_ready stay low; new requests wait; no request is lost.
- Requester inputs: may change while not handshaken; only values present at the handshake cycle are used.
- Reset mid-EXEC/RESP: returns to IDLE next edge; rsp_valid never asserts for the dropped op.

Optional Feature:
- Macro: ADD32_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins contention; the round-robin pointer and FIRST_GRANT are unused.
- Undefined: round-robin as above.

Test Plan:
- Req0 add, A=5, B=3, m=0, rsp_ready0=1 -> req_ready0 in cycle N; rsp_valid0 in N+2 with S=8, CF=0, OF=0, zero=0; rsp_valid1 stays 0.
- Req1 subtract, A=5, B=5 -> S=0, zero=1, CF=0. Then A=3, B=5 -> S=0xFFFFFFFE, CF=1, OF=0.
- Req0 add, A=0x7FFFFFFF, B=1 -> S=0x80000000, OF=1, CF=0. Then A=0xFFFFFFFF, B=1 -> S=0, CF=1, zero=1.
- Both valid continuously, 4 ops -> grant order 0,1,0,1 (FIRST_GRANT=0). With ADD32_ARB_FIXED_PRIO_EN: 0,0,0,0 and req_ready1 never asserted.
- rsp_ready0 held low 5 cycles in RESP while req_valid1=1 -> rsp_s/flags stable, req_ready0=req_ready1=0, busy=1. Release -> req1 accepted the cycle after.
- rst_n=0 for one cycle during EXEC -> next cycle state IDLE, busy=0, add_a=add_b=0, no rsp_valid for that op; a new request afterwards completes normally.
